// File: rtl/alu_pkg.sv
// Shared types and defaults for the multicycle execute-stage ALU.
package alu_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_SHAMT_W    = $clog2(DEF_DATA_WIDTH);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_XOR = 4'b0010,
        OP_OR  = 4'b0011,
        OP_AND = 4'b0100,
        OP_SLT = 4'b0101,
        OP_SRA = 4'b0110,
        OP_SRL = 4'b0111,
        OP_SLL = 4'b1000,
        OP_BNE = 4'b1010,
        OP_BLT = 4'b1011,
        OP_BGE = 4'b1100,
        OP_BEQ = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SRA) || (op == OP_SRL) || (op == OP_SLL);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: add/sub/logic/slt and branch compares.
// Shift ops and undefined codes produce zero here; the top handles shifts.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [3:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_c_o,
    output logic                  br_c_o
);

    logic lt_s_c;
    logic eq_c;

    assign lt_s_c = $signed(a_i) < $signed(b_i);
    assign eq_c   = (a_i == b_i);

    always_comb begin
        result_c_o = '0;
        br_c_o     = 1'b0;
        case (op_i)
            OP_ADD:  result_c_o = a_i + b_i;
            OP_SUB:  result_c_o = a_i - b_i;
            OP_XOR:  result_c_o = a_i ^ b_i;
            OP_OR:   result_c_o = a_i | b_i;
            OP_AND:  result_c_o = a_i & b_i;
            OP_SLT:  result_c_o = DATA_WIDTH'(lt_s_c);
            OP_BNE:  br_c_o     = !eq_c;
            OP_BLT:  br_c_o     = lt_s_c;
            OP_BGE:  br_c_o     = !lt_s_c;
            OP_BEQ:  br_c_o     = eq_c;
            default: ;
        endcase
        // Branches also report the condition zero-extended on the result bus.
        if ((op_i == OP_BNE) || (op_i == OP_BLT) || (op_i == OP_BGE) || (op_i == OP_BEQ)) begin
            result_c_o = DATA_WIDTH'(br_c_o);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes; shifts iterate SHIFT_STEP
// bits per cycle while everything else completes in one registered cycle.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  BrTaken,
    output logic                  busy
);

    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
    localparam int unsigned STEP_W  = $clog2(SHIFT_STEP + 1);
    localparam int unsigned CNT_W   = (SHAMT_W > STEP_W) ? SHAMT_W : STEP_W;

    alu_state_e            state_q;
    alu_op_e               kind_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0] result_q;
    logic [CNT_W-1:0]      rem_q;
    logic [CNT_W-1:0]      rem_d;
    logic [CNT_W-1:0]      step_c;
    logic                  br_q;

    logic [DATA_WIDTH-1:0] core_result_c;
    logic                  core_br_c;
    logic                  accept_c;
    logic                  shift_op_c;
    logic [SHAMT_W-1:0]    shamt_c;

    alu_comb_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .op_i       (Operation),
        .a_i        (SrcA),
        .b_i        (SrcB),
        .result_c_o (core_result_c),
        .br_c_o     (core_br_c)
    );

    assign in_ready   = !reset && !flush &&
                        ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept_c   = in_valid && in_ready;
    assign shift_op_c = is_shift_op(Operation);
    assign shamt_c    = SrcB[SHAMT_W-1:0];

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SHIFT);
    assign ALUResult = result_q;
    assign BrTaken   = br_q;

    // One shift iteration: move by min(SHIFT_STEP, rem).
    always_comb begin
        step_c = (rem_q > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : rem_q;
        rem_d  = rem_q - step_c;
        acc_d  = acc_q << step_c;
        case (kind_q)
            OP_SRA:  acc_d = DATA_WIDTH'($signed(acc_q) >>> step_c);
            OP_SRL:  acc_d = acc_q >> step_c;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q  <= IDLE;
            kind_q   <= OP_ADD;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            br_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_c) begin
                        if (shift_op_c && (shamt_c != '0)) begin
                            acc_q   <= SrcA;
                            rem_q   <= CNT_W'(shamt_c);
                            kind_q  <= alu_op_e'(Operation);
                            state_q <= SHIFT;
                        end else begin
                            result_q <= shift_op_c ? SrcA : core_result_c;
                            br_q     <= core_br_c;
                            state_q  <= DONE;
                        end
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (rem_d == '0) begin
                        result_q <= acc_d;
                        br_q     <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (DATA_WIDTH=32, SHIFT_STEP=1).
module tb_alu_multicycle;

    typedef struct packed {
        logic [31:0] r;
        logic        br;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        BrTaken;
    logic        busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_multicycle #(
        .DATA_WIDTH (32),
        .SHIFT_STEP (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .BrTaken   (BrTaken),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference behaviour of the ALU, written from the op table.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   k;
        e.r  = 32'd0;
        e.br = 1'b0;
        k    = int'(b[4:0]);
        case (op)
            4'b0000: e.r = a + b;
            4'b0001: e.r = a - b;
            4'b0010: e.r = a ^ b;
            4'b0011: e.r = a | b;
            4'b0100: e.r = a & b;
            4'b0101: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0110: e.r = 32'($signed(a) >>> k);
            4'b0111: e.r = a >> k;
            4'b1000: e.r = a << k;
            4'b1010: e.br = (a != b);
            4'b1011: e.br = ($signed(a) < $signed(b));
            4'b1100: e.br = ($signed(a) >= $signed(b));
            4'b1101: e.br = (a == b);
            default: ;
        endcase
        if (op >= 4'b1010 && op <= 4'b1101) e.r = {31'd0, e.br};
        return e;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = 'x;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for in_ready, push its expectation on accept.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, output int waited);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        waited    = 0;
        #1;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (in_ready) begin
            sb.push_back(e);
            tick();
        end else begin
            waited = -1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!out_valid && n < 200) begin
            if (busy) nb++;
            tick();
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got out_valid=%b busy=%b in_ready=%b, expected 0 0 0", out_valid, busy, in_ready);
        end
        n_checks++;
        if (ALUResult !== 32'd0 || BrTaken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: got result=%h br=%b, expected 0 0", ALUResult, BrTaken);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_arith();
        int   w, n, nb;
        exp_t e;
        issue(4'b0000, 32'h7FFF_FFFF, 32'd1, '{32'h8000_0000, 1'b0}, w);
        wait_valid(n, nb);
        e = pop_exp();
        n_checks++;
        if (w < 0 || n != 0) begin
            n_fail++;
            $display("FAIL add_latency: got wait=%0d extra=%0d, expected >=0 and 0", w, n);
        end
        n_checks++;
        if (ALUResult !== e.r || BrTaken !== e.br) begin
            n_fail++;
            $display("FAIL add_result: got %h/%b, expected %h/%b", ALUResult, BrTaken, e.r, e.br);
        end
        drain();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_release: got out_valid=%b, expected 0", out_valid);
        end
        issue(4'b0001, 32'd5, 32'd7, '{32'hFFFF_FFFE, 1'b0}, w);
        wait_valid(n, nb);
        e = pop_exp();
        n_checks++;
        if (n != 0 || ALUResult !== e.r || BrTaken !== e.br) begin
            n_fail++;
            $display("FAIL sub_result: got %h/%b after %0d, expected %h/%b after 0", ALUResult, BrTaken, n, e.r, e.br);
        end
        drain();
    endtask

    task automatic test_shift();
        int   w, n, nb;
        exp_t e;
        issue(4'b0110, 32'h8000_0000, 32'h0000_0024, '{32'hF800_0000, 1'b0}, w);
        wait_valid(n, nb);
        e = pop_exp();
        n_checks++;
        if (n != 4 || nb != 4) begin
            n_fail++;
            $display("FAIL sra_latency: got wait=%0d busy=%0d, expected 4 4", n, nb);
        end
        n_checks++;
        if (ALUResult !== e.r || BrTaken !== e.br) begin
            n_fail++;
            $display("FAIL sra_result: got %h/%b, expected %h/%b", ALUResult, BrTaken, e.r, e.br);
        end
        drain();
        issue(4'b0111, 32'h8000_0000, 32'h0000_0024, '{32'h0800_0000, 1'b0}, w);
        wait_valid(n, nb);
        e = pop_exp();
        n_checks++;
        if (n != 4 || ALUResult !== e.r) begin
            n_fail++;
            $display("FAIL srl_result: got %h after %0d, expected %h after 4", ALUResult, n, e.r);
        end
        drain();
        issue(4'b1000, 32'h1234_5678, 32'h0000_0020, '{32'h1234_5678, 1'b0}, w);
        wait_valid(n, nb);
        e = pop_exp();
        n_checks++;
        if (n != 0 || nb != 0 || ALUResult !== e.r) begin
            n_fail++;
            $display("FAIL sll_k0: got %h after %0d busy=%0d, expected %h after 0 busy 0", ALUResult, n, nb, e.r);
        end
        drain();
    endtask

    task automatic test_branch();
        logic [3:0]  ops [5] = '{4'b1011, 4'b1100, 4'b1101, 4'b1010, 4'b0101};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'hFFFF_FFFF};
        logic [31:0] bs  [5] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd1};
        logic [31:0] ers [5] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
        logic        ebs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int   w, n, nb;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], '{ers[i], ebs[i]}, w);
            wait_valid(n, nb);
            e = pop_exp();
            n_checks++;
            if (n != 0 || ALUResult !== e.r || BrTaken !== e.br) begin
                n_fail++;
                $display("FAIL branch_%0d op=%b: got %h/%b after %0d, expected %h/%b after 0",
                         i, ops[i], ALUResult, BrTaken, n, e.r, e.br);
            end
            drain();
        end
    endtask

    task automatic test_back_pressure();
        int   w, n, nb;
        exp_t e;
        issue(4'b0000, 32'd1, 32'd2, '{32'd3, 1'b0}, w);
        wait_valid(n, nb);
        e = pop_exp();
        Operation = 4'b0010;
        SrcA      = 32'h0000_F0F0;
        SrcB      = 32'h0000_FF00;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== e.r || BrTaken !== e.br) begin
                n_fail++;
                $display("FAIL hold_%0d: got valid=%b ready=%b result=%h, expected 1 0 %h",
                         c, out_valid, in_ready, ALUResult, e.r);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got in_ready=%b, expected 1", in_ready);
        end
        if (in_ready) sb.push_back('{32'h0000_0FF0, 1'b0});
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || ALUResult !== e.r || BrTaken !== e.br) begin
            n_fail++;
            $display("FAIL b2b_result: got valid=%b result=%h, expected 1 %h", out_valid, ALUResult, e.r);
        end
        drain();
    endtask

    task automatic test_flush();
        int   w, n, nb;
        exp_t e;
        issue(4'b1000, 32'd1, 32'd31, '{32'h8000_0000, 1'b0}, w);
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pre: got busy=%b valid=%b, expected 1 0", busy, out_valid);
        end
        flush = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got in_ready=%b, expected 0", in_ready);
        end
        tick();
        flush = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || ALUResult !== 32'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_post: got busy=%b valid=%b result=%h ready=%b, expected 0 0 0 1",
                     busy, out_valid, ALUResult, in_ready);
        end
        issue(4'b0000, 32'd10, 32'd20, '{32'd30, 1'b0}, w);
        wait_valid(n, nb);
        e = pop_exp();
        n_checks++;
        if (n != 0 || ALUResult !== e.r || BrTaken !== e.br) begin
            n_fail++;
            $display("FAIL flush_next: got %h after %0d, expected %h after 0", ALUResult, n, e.r);
        end
        drain();
    endtask

    task automatic test_reset_mid_done();
        logic [3:0] undef [3] = '{4'b1110, 4'b1001, 4'b1111};
        int   w, n, nb;
        exp_t e;
        issue(4'b0011, 32'h0000_00A5, 32'h0000_005A, '{32'h0000_00FF, 1'b0}, w);
        wait_valid(n, nb);
        e = pop_exp();
        n_checks++;
        if (ALUResult !== e.r || BrTaken !== e.br) begin
            n_fail++;
            $display("FAIL or_result: got %h/%b, expected %h/%b", ALUResult, BrTaken, e.r, e.br);
        end
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ALUResult !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_done: got valid=%b result=%h busy=%b ready=%b, expected 0 0 0 1",
                     out_valid, ALUResult, busy, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            issue(4'b1101, 32'd5, 32'd5, '{32'd1, 1'b1}, w);
            wait_valid(n, nb);
            e = pop_exp();
            drain();
            issue(undef[i], 32'd5, 32'd5, '{32'd0, 1'b0}, w);
            wait_valid(n, nb);
            e = pop_exp();
            n_checks++;
            if (n != 0 || ALUResult !== e.r || BrTaken !== e.br) begin
                n_fail++;
                $display("FAIL undef_%b: got %h/%b after %0d, expected %h/%b after 0",
                         undef[i], ALUResult, BrTaken, n, e.r, e.br);
            end
            drain();
        end
    endtask

    // Random ops with random in_valid/out_ready against the scoreboard.
    task automatic test_back_to_back();
        int          accepted = 0;
        int          cycles   = 0;
        logic        took;
        logic [3:0]  op;
        logic [31:0] a, b;
        exp_t        e;
        sb.delete();
        op = 4'($urandom_range(0, 15));
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        while ((accepted < 40 || sb.size() != 0) && cycles < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (accepted < 40) && ($urandom_range(0, 4) != 0);
            Operation = op;
            SrcA      = a;
            SrcB      = b;
            #1;
            if (out_valid && out_ready) begin
                e = pop_exp();
                n_checks++;
                if (ALUResult !== e.r || BrTaken !== e.br) begin
                    n_fail++;
                    $display("FAIL rand_%0d: got %h/%b, expected %h/%b", cycles, ALUResult, BrTaken, e.r, e.br);
                end
            end
            took = in_valid && in_ready;
            if (took) sb.push_back(model(op, a, b));
            tick();
            cycles++;
            if (took) begin
                accepted++;
                op = 4'($urandom_range(0, 15));
                a  = $urandom;
                b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (accepted != 40 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout: got accepted=%0d pending=%0d, expected 40 0", accepted, sb.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Operation = 4'd0;
        SrcA      = 32'd0;
        SrcB      = 32'd0;
        test_reset();
        test_arith();
        test_shift();
        test_branch();
        test_back_pressure();
        test_flush();
        test_reset_mid_done();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
